tscomp_pipe: RTL and testbench
==============================

TSCOMP_PIPE -- requirements
Module: tscomp_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64: data width in bits, at least 2.
REQ-002 SHALL have parameter DEPTH, default 7: pipeline stages from input to output, at least 1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data and in_mode are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts input this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: operand, two's complement.
REQ-008 SHALL have port in_mode, input, 2 bits: 00 PASS, 01 NEG, 10 ABS, 11 NEG.
REQ-009 SHALL have port flush, input, 1 bit: synchronous discard of all in-flight items.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data and out_ovf hold a result.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port out_data, output, WIDTH bits: result.
REQ-013 SHALL have port out_ovf, output, 1 bit: result not representable in WIDTH bits.

Function
REQ-014 SHALL compute the result combinationally from in_data/in_mode:
- PASS: result = in_data.
- NEG: result = ~in_data + 1, modulo 2^WIDTH.
- ABS: result = NEG result if in_data MSB is 1, else in_data.
REQ-015 SHALL set ovf=1 only when the mode is NEG or ABS and in_data = 1 followed by WIDTH-1 zeros; the result is then in_data unchanged. Zero negates to zero with ovf=0.
REQ-016 SHALL carry {valid, result, ovf} through DEPTH register stages; out_* come from the last stage.
REQ-017 SHALL define advance = !out_valid || out_ready; when advance=1 every stage shifts by one, otherwise all stages hold.
REQ-018 SHALL drive in_ready = advance && !flush.
REQ-019 SHALL transfer an input only when in_valid && in_ready; otherwise stage 1 loads valid=0 when advancing.
REQ-020 SHALL give latency exactly DEPTH cycles from input transfer to out_valid when out_ready is held high; throughput one item per cycle.
REQ-021 SHALL keep out_data/out_ovf stable while out_valid=1 and out_ready=0.
REQ-022 SHALL make flush=1 clear every stage valid bit at the next edge; the input in the same cycle is not accepted; flush overrides advance.
REQ-023 SHALL preserve order, with no drop or duplication except under flush or reset.
REQ-024 SHALL let data and ovf registers of invalid stages hold don't-care values; only valid bits need reset.

Reset
REQ-025 SHALL, while rst_n=0, immediately clear all stage valid bits (out_valid=0), out_data=0 and out_ovf=0, independent of clk.
REQ-026 SHALL, on a reset asserted mid-operation, lose all in-flight items; the first transfer after rst_n deasserts behaves as from an empty pipeline.
REQ-027 SHALL show in_ready=1 out of reset when flush=0.

Structure
REQ-028 SHALL place the mode encodings MODE_PASS=2'b00, MODE_NEG=2'b01 and MODE_ABS=2'b10 in shared package tscomp_pkg.
REQ-029 SHALL use one sub-module, tscomp_stage: a single enabled, async-reset register stage of {valid, WIDTH data, ovf}, instantiated DEPTH times in a generate loop.
REQ-030 SHALL keep the negate/abs logic in tscomp_pipe, ahead of stage 1.

Verification
REQ-031 SHALL cover, with WIDTH=64, DEPTH=7 and out_ready=1: NEG of 64'h1111111111111111 -> out_data 64'hEEEEEEEEEEEEEEEF, ovf=0, out_valid exactly 7 cycles later.
REQ-032 SHALL cover ABS of 64'hFFFFFFFFFFFFFFFB -> 64'h0000000000000005; ABS of 64'h8000000000000000 -> 64'h8000000000000000 with ovf=1; NEG of 0 -> 0 with ovf=0.
REQ-033 SHALL cover back-to-back inputs 1..10 with mode PASS and out_ready low for cycles 9..12 -> in_ready low while stalled, outputs 1..10 in order, none lost, out_data stable during the stall.
REQ-034 SHALL cover flush with 3 items in flight -> out_valid never asserts for them, and a new item issued after flush emerges 7 cycles later.
REQ-035 SHALL cover rst_n low mid-stream, between clock edges -> out_valid=0 and out_data=0 immediately; after release, NEG of 5 -> 64'hFFFFFFFFFFFFFFFB after 7 cycles.
REQ-036 SHALL cover WIDTH=8, DEPTH=1: NEG of 8'h80 -> 8'h80 with ovf=1 one cycle later; NEG of 8'h01 -> 8'hFF.

Source files
------------

// File: rtl/tscomp_pkg.sv
// Shared definitions for the two's-complement negate/abs pipeline.
package tscomp_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ABS  = 2'b10,
        MODE_NEG2 = 2'b11
    } mode_e;

endpackage

// File: rtl/tscomp_stage.sv
// One enabled pipeline register holding {valid, data, ovf}.
module tscomp_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    input  logic             d_ovf,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data,
    output logic             q_ovf
);

    // Data and ovf are cleared as well so the last stage reads as zero in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_ovf   <= 1'b0;
        end else if (en) begin
            q_valid <= d_valid;
            q_data  <= d_data;
            q_ovf   <= d_ovf;
        end
    end

endmodule

// File: rtl/tscomp_pipe.sv
// Two's-complement PASS/NEG/ABS unit followed by a DEPTH-stage
// valid/ready pipeline with flush.
module tscomp_pipe
    import tscomp_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             advance;
    logic             negate;
    logic             is_min;
    logic [WIDTH-1:0] neg_data;

    logic [DEPTH:0]   v;
    logic [WIDTH-1:0] d [DEPTH+1];
    logic [DEPTH:0]   o;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !flush;

    always_comb begin
        negate = 1'b0;
        case (mode_e'(in_mode))
            MODE_PASS: negate = 1'b0;
            MODE_ABS:  negate = in_data[WIDTH-1];
            default:   negate = 1'b1;
        endcase
    end

    // The most negative value negates to itself, which is exactly the overflow result.
    assign neg_data = ~in_data + ONE;
    assign is_min   = (in_data == MIN_VAL);

    assign v[0] = in_valid && in_ready;
    assign d[0] = negate ? neg_data : in_data;
    assign o[0] = (mode_e'(in_mode) != MODE_PASS) && is_min;

    // Flush forces every stage to load and clears all valid bits.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        tscomp_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (advance || flush),
            .d_valid (v[k] && !flush),
            .d_data  (d[k]),
            .d_ovf   (o[k]),
            .q_valid (v[k+1]),
            .q_data  (d[k+1]),
            .q_ovf   (o[k+1])
        );
    end

    assign out_valid = v[DEPTH];
    assign out_data  = d[DEPTH];
    assign out_ovf   = o[DEPTH];

endmodule

// File: tb/tb_tscomp_pipe.sv
// Bench for tscomp_pipe: queue-based reference model with per-cycle compare,
// plus directed literal checks at WIDTH=64/DEPTH=7 and WIDTH=8/DEPTH=1.
module tb_tscomp_pipe;

    localparam int DEPTH = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic [1:0]  in_mode = 2'b00;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        out_ovf;

    logic        v8 = 1'b0;
    logic        r8;
    logic [7:0]  d8 = '0;
    logic [1:0]  m8 = 2'b00;
    logic        f8 = 1'b0;
    logic        ov8;
    logic        ordy8 = 1'b1;
    logic [7:0]  od8;
    logic        of8;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tscomp_pipe #(.WIDTH(64), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    tscomp_pipe #(.WIDTH(8), .DEPTH(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
        .in_data(d8), .in_mode(m8), .flush(f8), .out_valid(ov8),
        .out_ready(ordy8), .out_data(od8), .out_ovf(of8)
    );

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: each accepted item ages by one per advancing edge and is
    // presented once its remaining count hits zero.
    typedef struct {
        logic [63:0] data;
        logic        ovf;
        int          rem;
    } item_t;

    item_t q[$];
    bit    m_head;
    bit    m_adv;
    bit    ev;

    function automatic item_t modelItem(input logic [63:0] x, input logic [1:0] m);
        item_t it;
        it.data = x;
        if (m == 2'b01 || m == 2'b11 || (m == 2'b10 && x[63]))
            it.data = 64'd0 - x;
        it.ovf = (m != 2'b00) && (x == 64'h8000_0000_0000_0000);
        it.rem = DEPTH - 1;
        return it;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            m_head = (q.size() > 0) && (q[0].rem == 0);
            m_adv  = !m_head || out_ready;
            if (flush) begin
                q.delete();
            end else if (m_adv) begin
                if (m_head) void'(q.pop_front());
                foreach (q[i]) q[i].rem = q[i].rem - 1;
                if (in_valid) q.push_back(modelItem(in_data, in_mode));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            checkVal("reset_valid", 64'(out_valid), 64'd0);
            checkVal("reset_data", out_data, 64'd0);
            checkVal("reset_ovf", 64'(out_ovf), 64'd0);
        end else begin
            ev = (q.size() > 0) && (q[0].rem == 0);
            checkVal("model_valid", 64'(out_valid), 64'(ev));
            if (ev) begin
                checkVal("model_data", out_data, q[0].data);
                checkVal("model_ovf", 64'(out_ovf), 64'(q[0].ovf));
            end
            checkVal("model_ready", 64'(in_ready), 64'((!ev || out_ready) && !flush));
        end
    end

    task automatic applyStimulus(input logic v, input logic [63:0] x, input logic [1:0] m,
                                 input logic f, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = x;
        in_mode   = m;
        flush     = f;
        out_ready = r;
    endtask

    task automatic sendOne(input logic [63:0] x, input logic [1:0] m, output int c);
        applyStimulus(1'b1, x, m, 1'b0, 1'b1);
        c = cyc;
        applyStimulus(1'b0, 64'd0, 2'b00, 1'b0, 1'b1);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] exp, input logic eovf,
                               input int c);
        int  n = 0;
        bit  seen = 0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1;
        end
        if (!seen) begin
            vectors++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no out_valid, expected one within 30 cycles", name);
        end else begin
            checkVal({name, "_data"}, out_data, exp);
            checkVal({name, "_ovf"}, 64'(out_ovf), 64'(eovf));
            checkVal({name, "_latency"}, 64'(cyc - c), 64'(DEPTH));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected one before 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int idx;
        int expn;
        int got;

        repeat (2) @(negedge clk);
        checkVal("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        checkVal("ready_after_reset", 64'(in_ready), 64'd1);
        checkVal("valid_after_reset", 64'(out_valid), 64'd0);

        sendOne(64'h1111111111111111, 2'b01, c);
        checkOutput("neg_1111", 64'hEEEEEEEEEEEEEEEF, 1'b0, c);
        sendOne(64'hFFFFFFFFFFFFFFFB, 2'b10, c);
        checkOutput("abs_m5", 64'h0000000000000005, 1'b0, c);
        sendOne(64'h8000000000000000, 2'b10, c);
        checkOutput("abs_min", 64'h8000000000000000, 1'b1, c);
        sendOne(64'h0, 2'b01, c);
        checkOutput("neg_zero", 64'h0, 1'b0, c);
        sendOne(64'h2, 2'b11, c);
        checkOutput("neg11_two", 64'hFFFFFFFFFFFFFFFE, 1'b0, c);
        sendOne(64'h0000000000000009, 2'b10, c);
        checkOutput("abs_pos", 64'h0000000000000009, 1'b0, c);

        // Back-to-back stream with a four-cycle downstream stall.
        idx = 1;
        expn = 1;
        got = 0;
        for (int k = 0; k < 30; k++) begin
            applyStimulus(idx <= 10, 64'(idx), 2'b00, 1'b0, !(k >= 9 && k <= 12));
            @(negedge clk);
            if (!out_ready) begin
                checkVal("stall_in_ready", 64'(in_ready), 64'd0);
                checkVal("stall_hold", out_data, 64'd3);
            end
            if (out_valid && out_ready) begin
                checkVal("stream_order", out_data, 64'(expn));
                expn++;
                got++;
            end
            if (in_valid && in_ready) idx++;
        end
        applyStimulus(1'b0, 64'd0, 2'b00, 1'b0, 1'b1);
        checkVal("stream_count", 64'(got), 64'd10);

        // Three items in flight, then flush with a competing input.
        applyStimulus(1'b1, 64'hA1, 2'b00, 1'b0, 1'b1);
        applyStimulus(1'b1, 64'hA2, 2'b00, 1'b0, 1'b1);
        applyStimulus(1'b1, 64'hA3, 2'b00, 1'b0, 1'b1);
        applyStimulus(1'b1, 64'hA4, 2'b00, 1'b1, 1'b1);
        @(negedge clk);
        checkVal("flush_in_ready", 64'(in_ready), 64'd0);
        sendOne(64'h55, 2'b01, c);
        checkOutput("after_flush", 64'hFFFFFFFFFFFFFFAB, 1'b0, c);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b1, 64'(i + 256), 2'b00, 1'b0, 1'b1);
        checkVal("pre_reset_valid", 64'(out_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        checkVal("async_valid", 64'(out_valid), 64'd0);
        checkVal("async_data", out_data, 64'd0);
        checkVal("async_ovf", 64'(out_ovf), 64'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        sendOne(64'd5, 2'b01, c);
        checkOutput("neg_five", 64'hFFFFFFFFFFFFFFFB, 1'b0, c);

        // Narrow single-stage instance.
        @(posedge clk);
        #1;
        v8 = 1'b1;
        d8 = 8'h80;
        m8 = 2'b01;
        @(posedge clk);
        #1;
        d8 = 8'h01;
        @(negedge clk);
        checkVal("w8_min_valid", 64'(ov8), 64'd1);
        checkVal("w8_min_data", 64'(od8), 64'h80);
        checkVal("w8_min_ovf", 64'(of8), 64'd1);
        @(posedge clk);
        #1;
        v8 = 1'b0;
        @(negedge clk);
        checkVal("w8_one_valid", 64'(ov8), 64'd1);
        checkVal("w8_one_data", 64'(od8), 64'hFF);
        checkVal("w8_one_ovf", 64'(of8), 64'd0);
        @(negedge clk);
        checkVal("w8_idle_valid", 64'(ov8), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
